// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display driver.
//   - FSM state encoding for the load/convert/commit controller
//   - NUM_DIGITS and the blank glyph
//   - 16-entry hex glyph table, segments {g,f,e,d,c,b,a}, active high
package seg_pkg;

  localparam int NUM_DIGITS = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } seg_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Entry [n] is the glyph for nibble n; listed from F down to 0.
  localparam logic [15:0][6:0] GLYPH_TBL = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
    return GLYPH_TBL[nib];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3).
// A start pulse loads bin_in; the next 8 cycles each perform one
// add-3-then-shift step. done is high during the cycle whose closing edge
// performs the final step, so bcd holds the result from the following
// cycle until the next start.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : load bin_in and begin conversion
//   bin_in [7:0] : value to convert
//   done         : last step completes on the coming edge
//   bcd [2:0][3:0] : {hundreds, tens, ones}
module bin2bcd_seq (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [7:0]      bin_in,
  output logic            done,
  output logic [2:0][3:0] bcd
);

  logic [7:0]       sh;
  logic [2:0][3:0]  acc;
  logic [2:0][3:0]  adj;
  logic [19:0]      shifted;
  logic [2:0]       cnt;
  logic             active;

  // Correct every BCD nibble that would overflow past 9 when doubled.
  always_comb begin
    for (int i = 0; i < 3; i++)
      adj[i] = (acc[i] >= 4'd5) ? acc[i] + 4'd3 : acc[i];
    shifted = {adj, sh} << 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh     <= '0;
      acc    <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      sh     <= bin_in;
      acc    <= '0;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      acc <= shifted[19:8];
      sh  <= shifted[7:0];
      cnt <= cnt + 3'd1;
      if (cnt == 3'd7) active <= 1'b0;
    end
  end

  assign done = active && (cnt == 3'd7);
  assign bcd  = acc;

endmodule

// File: rtl/seg_display_driver.sv
// Multiplexed 3-digit seven-segment driver for an 8-bit value.
// A free-running prescaler steps a digit index 0->1->2->0; the lit digit's
// glyph is registered onto seg_out/dp_out/digit_an. A load captures the
// value in hex (2 digits) or decimal (3 digits via bin2bcd_seq); the new
// digits are copied into the display register only at the scan wrap so a
// frame never mixes old and new digits.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   data_in [7:0]   : value to display
//   load            : one-cycle display request (accepted only when idle)
//   dec_mode        : 1 = decimal, 0 = hex (sampled with load)
//   blank_lz        : blank leading zeros (sampled with load)
//   flag_in         : shown on digit 0 decimal point (sampled with load)
//   seg_out [6:0]   : segments {g,f,e,d,c,b,a}
//   dp_out          : decimal point
//   digit_an [2:0]  : one-hot digit enable, bit0 = least significant
//   busy            : conversion or commit pending
module seg_display_driver
  import seg_pkg::*;
#(
  parameter logic [23:0] REFRESH_DIV = 24'd10_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       load,
  input  logic       dec_mode,
  input  logic       blank_lz,
  input  logic       flag_in,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [2:0] digit_an,
  output logic       busy
);

  // ---------------- scan ----------------
  logic [23:0] presc;
  logic [1:0]  idx;
  logic        tc;
  logic        wrap;

  assign tc   = (presc == REFRESH_DIV - 24'd1);
  assign wrap = tc && (idx == 2'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (tc) begin
      presc <= '0;
      idx   <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      presc <= presc + 24'd1;
    end
  end

  // ---------------- controller ----------------
  seg_state_t state, state_nx;
  logic       accept;
  logic       conv_start;
  logic       conv_done;
  logic       commit;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    conv_start = 1'b0;
    commit     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load) begin
          accept = 1'b1;
          if (dec_mode) begin
            conv_start = 1'b1;
            state_nx   = ST_CONVERT;
          end else begin
            state_nx   = ST_COMMIT;
          end
        end
      end
      ST_CONVERT: if (conv_done) state_nx = ST_COMMIT;
      ST_COMMIT: begin
        if (wrap) begin
          commit   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // ---------------- load capture ----------------
  logic       pend_dec;
  logic       pend_blz;
  logic       pend_flag;
  logic [7:0] pend_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_dec  <= 1'b0;
      pend_blz  <= 1'b0;
      pend_flag <= 1'b0;
      pend_val  <= '0;
    end else if (accept) begin
      pend_dec  <= dec_mode;
      pend_blz  <= blank_lz;
      pend_flag <= flag_in;
      pend_val  <= data_in;
    end
  end

  logic [2:0][3:0] bcd;

  bin2bcd_seq u_b2b (
    .clk    (clk),
    .reset  (reset),
    .start  (conv_start),
    .bin_in (data_in),
    .done   (conv_done),
    .bcd    (bcd)
  );

  // Digits/blanks to commit. The converter result stays stable from the
  // end of CONVERT until the next start, which cannot happen before commit.
  logic [NUM_DIGITS-1:0][3:0] new_dig;
  logic [NUM_DIGITS-1:0]      new_blank;

  always_comb begin
    new_dig   = '0;
    new_blank = '0;
    if (pend_dec) begin
      new_dig      = bcd;
      new_blank[2] = pend_blz && (bcd[2] == 4'd0);
      new_blank[1] = pend_blz && (bcd[2] == 4'd0) && (bcd[1] == 4'd0);
    end else begin
      new_dig      = {4'h0, pend_val[7:4], pend_val[3:0]};
      new_blank[2] = 1'b1;
      new_blank[1] = pend_blz && (pend_val[7:4] == 4'h0);
    end
    new_blank[0] = 1'b0;
  end

  // ---------------- display register ----------------
  logic [NUM_DIGITS-1:0][3:0] disp_dig;
  logic [NUM_DIGITS-1:0]      disp_blank;
  logic                       disp_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_dig   <= '0;
      disp_blank <= '1;
      disp_flag  <= 1'b0;
    end else if (commit) begin
      disp_dig   <= new_dig;
      disp_blank <= new_blank;
      disp_flag  <= pend_flag;
    end
  end

  // ---------------- output register ----------------
  logic [3:0] cur_dig;
  logic       cur_blank;
  logic [2:0] an_nx;

  always_comb begin
    cur_dig   = disp_dig[0];
    cur_blank = disp_blank[0];
    an_nx     = 3'b001;
    case (idx)
      2'd1: begin
        cur_dig   = disp_dig[1];
        cur_blank = disp_blank[1];
        an_nx     = 3'b010;
      end
      2'd2: begin
        cur_dig   = disp_dig[2];
        cur_blank = disp_blank[2];
        an_nx     = 3'b100;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_out  <= SEG_BLANK;
      dp_out   <= 1'b0;
      digit_an <= 3'b001;
    end else begin
      seg_out  <= cur_blank ? SEG_BLANK : seg_glyph(cur_dig);
      dp_out   <= (idx == 2'd0) && disp_flag;
      digit_an <= an_nx;
    end
  end

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver with REFRESH_DIV = 4.
module tb_seg_display_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       load;
  logic       dec_mode;
  logic       blank_lz;
  logic       flag_in;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [2:0] digit_an;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;

  seg_display_driver #(.REFRESH_DIV(24'd4)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .load     (load),
    .dec_mode (dec_mode),
    .blank_lz (blank_lz),
    .flag_in  (flag_in),
    .seg_out  (seg_out),
    .dp_out   (dp_out),
    .digit_an (digit_an),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] d, input logic dec, input logic blz,
                         input logic flg);
    data_in  = d;
    dec_mode = dec;
    blank_lz = blz;
    flag_in  = flg;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  // Returns number of sampled cycles busy was high (bounded).
  task automatic wait_idle(input string tag, output int cyc);
    cyc = 0;
    while (busy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic show_digits(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic edp);
    logic [6:0] exp_seg [3];
    logic [2:0] exp_an;
    exp_seg[0] = e0;
    exp_seg[1] = e1;
    exp_seg[2] = e2;
    for (int d = 0; d < 3; d++) begin
      int t;
      exp_an = 3'(1 << d);
      t = 0;
      while (digit_an !== exp_an && t < 30) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("%s_an%0d", tag, d), digit_an, exp_an);
      chk($sformatf("%s_seg%0d", tag, d), seg_out, exp_seg[d]);
      chk($sformatf("%s_dp%0d", tag, d), dp_out, (d == 0) ? edp : 1'b0);
    end
  endtask

  // Extra boundary vectors: {value, dec, blz, flag, d0, d1, d2}
  logic [7:0] xv_val [4] = '{8'h05, 8'd0, 8'd10, 8'hA0};
  logic       xv_dec [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [6:0] xv_d0  [4] = '{7'h6D, 7'h3F, 7'h3F, 7'h3F};
  logic [6:0] xv_d1  [4] = '{7'h00, 7'h00, 7'h06, 7'h77};

  initial begin
    int cyc;
    reset = 1'b1; load = 1'b0; data_in = '0;
    dec_mode = 1'b0; blank_lz = 1'b0; flag_in = 1'b0;

    // reset: two cycles
    @(negedge clk);
    @(negedge clk);
    chk("rst_seg", seg_out, 7'h00);
    chk("rst_dp", dp_out, 0);
    chk("rst_an", digit_an, 3'b001);
    chk("rst_busy", busy, 0);
    reset = 1'b0;

    // scan timing: digit 0 lit for 4 cycles, then digit 1
    repeat (4) @(negedge clk);
    chk("scan_hold", digit_an, 3'b001);
    @(negedge clk);
    chk("scan_step", digit_an, 3'b010);
    chk("scan_blank", seg_out, 7'h00);

    // hex 3C, flag set
    do_load(8'h3C, 1'b0, 1'b0, 1'b1);
    chk("hex_busy", busy, 1);
    wait_idle("hex", cyc);
    repeat (2) @(negedge clk);
    show_digits("hex3c", 7'h39, 7'h4F, 7'h00, 1'b1);

    // decimal 255
    do_load(8'd255, 1'b1, 1'b0, 1'b0);
    wait_idle("d255", cyc);
    chk("d255_busylen", (cyc >= 9), 1);
    repeat (2) @(negedge clk);
    show_digits("d255", 7'h6D, 7'h6D, 7'h5B, 1'b0);

    // decimal 7 with leading-zero blanking
    do_load(8'd7, 1'b1, 1'b1, 1'b0);
    wait_idle("d7", cyc);
    repeat (2) @(negedge clk);
    show_digits("d7", 7'h07, 7'h00, 7'h00, 1'b0);

    // boundary vectors
    for (int i = 0; i < 4; i++) begin
      do_load(xv_val[i], xv_dec[i], 1'b1, 1'b0);
      wait_idle($sformatf("xv%0d", i), cyc);
      repeat (2) @(negedge clk);
      show_digits($sformatf("xv%0d", i), xv_d0[i], xv_d1[i], 7'h00, 1'b0);
    end

    // 100 then 200 two cycles later: second load ignored
    do_load(8'd100, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    do_load(8'd200, 1'b1, 1'b0, 1'b0);
    wait_idle("d100", cyc);
    repeat (2) @(negedge clk);
    show_digits("d100", 7'h3F, 7'h3F, 7'h06, 1'b0);
    repeat (15) @(negedge clk);
    show_digits("d100b", 7'h3F, 7'h3F, 7'h06, 1'b0);

    // reset mid-CONVERT
    do_load(8'd88, 1'b1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("abort_busy_pre", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_seg", seg_out, 7'h00);
    chk("abort_an", digit_an, 3'b001);
    chk("abort_dp", dp_out, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    show_digits("abort", 7'h00, 7'h00, 7'h00, 1'b0);
    repeat (20) @(negedge clk);
    chk("abort_busy_late", busy, 0);
    show_digits("abortb", 7'h00, 7'h00, 7'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
